// File: rtl/core_rvfi_rob.sv
// RVFI retirement buffer: groups of up to NRET retirements held in
// program order until late rd/load data arrives, then put on rvfi_*.
// Ports: g_clk/g_reset, n_* retirement lanes and late fill, rvfi_*
// trace bus, full, sticky err_ovf/err_fill.
module core_rvfi_rob #(
  parameter int NRET       = 1,
  parameter int XLEN       = 32,
  parameter int ILEN       = 32,
  parameter int DEPTH      = 4,
  parameter int SKIP_FIRST = 1
) (
  input  logic                   g_clk,
  input  logic                   g_reset,
  input  logic [NRET-1:0]        n_valid,
  input  logic [NRET*ILEN-1:0]   n_insn,
  input  logic [NRET-1:0]        n_intr,
  input  logic [NRET-1:0]        n_trap,
  input  logic [NRET*5-1:0]      n_rs1_addr,
  input  logic [NRET*5-1:0]      n_rs2_addr,
  input  logic [NRET*XLEN-1:0]   n_rs1_rdata,
  input  logic [NRET*XLEN-1:0]   n_rs2_rdata,
  input  logic [NRET*5-1:0]      n_rd_addr,
  input  logic [NRET*XLEN-1:0]   n_rd_wdata,
  input  logic [NRET-1:0]        n_late,
  input  logic [NRET*XLEN-1:0]   n_pc_rdata,
  input  logic [NRET*XLEN-1:0]   n_pc_wdata,
  input  logic [NRET*XLEN-1:0]   n_mem_addr,
  input  logic [NRET*XLEN-1:0]   n_mem_wdata,
  input  logic [NRET*XLEN/8-1:0] n_mem_rmask,
  input  logic [NRET*XLEN/8-1:0] n_mem_wmask,
  input  logic [NRET*XLEN-1:0]   n_mem_rdata,
  input  logic                   n_fill_valid,
  input  logic [XLEN-1:0]        n_fill_rd_wdata,
  input  logic [XLEN-1:0]        n_fill_mem_rdata,
  output logic [NRET-1:0]        rvfi_valid,
  output logic [NRET*64-1:0]     rvfi_order,
  output logic [NRET*ILEN-1:0]   rvfi_insn,
  output logic [NRET-1:0]        rvfi_trap,
  output logic [NRET-1:0]        rvfi_intr,
  output logic [NRET*5-1:0]      rvfi_rs1_addr,
  output logic [NRET*5-1:0]      rvfi_rs2_addr,
  output logic [NRET*XLEN-1:0]   rvfi_rs1_rdata,
  output logic [NRET*XLEN-1:0]   rvfi_rs2_rdata,
  output logic [NRET*5-1:0]      rvfi_rd_addr,
  output logic [NRET*XLEN-1:0]   rvfi_rd_wdata,
  output logic [NRET*XLEN-1:0]   rvfi_pc_rdata,
  output logic [NRET*XLEN-1:0]   rvfi_pc_wdata,
  output logic [NRET*XLEN-1:0]   rvfi_mem_addr,
  output logic [NRET*XLEN/8-1:0] rvfi_mem_rmask,
  output logic [NRET*XLEN/8-1:0] rvfi_mem_wmask,
  output logic [NRET*XLEN-1:0]   rvfi_mem_rdata,
  output logic [NRET*XLEN-1:0]   rvfi_mem_wdata,
  output logic                   full,
  output logic                   err_ovf,
  output logic                   err_fill
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int MW = XLEN / 8;

  typedef struct packed {
    logic [NRET*ILEN-1:0] insn;
    logic [NRET-1:0]      trap;
    logic [NRET-1:0]      intr;
    logic [NRET*5-1:0]    rs1_addr;
    logic [NRET*5-1:0]    rs2_addr;
    logic [NRET*5-1:0]    rd_addr;
    logic [NRET*XLEN-1:0] rs1_rdata;
    logic [NRET*XLEN-1:0] rs2_rdata;
    logic [NRET*XLEN-1:0] rd_wdata;
    logic [NRET*XLEN-1:0] pc_rdata;
    logic [NRET*XLEN-1:0] pc_wdata;
    logic [NRET*XLEN-1:0] mem_addr;
    logic [NRET*XLEN-1:0] mem_wdata;
    logic [NRET*XLEN-1:0] mem_rdata;
    logic [NRET*MW-1:0]   mem_rmask;
    logic [NRET*MW-1:0]   mem_wmask;
  } rec_t;

  // late != 0 means the group is still waiting for fill data
  typedef struct packed {
    logic [NRET-1:0] valid;
    logic [NRET-1:0] late;
    rec_t            r;
  } grp_t;

  function automatic grp_t fill_grp(grp_t g,
                                    logic [XLEN-1:0] rd,
                                    logic [XLEN-1:0] mr);
    grp_t f;
    f = g;
    for (int l = 0; l < NRET; l++) begin
      if (g.late[l]) begin
        f.r.rd_wdata[l*XLEN +: XLEN]  = rd;
        f.r.mem_rdata[l*XLEN +: XLEN] = mr;
      end
    end
    f.late = '0;
    return f;
  endfunction

  grp_t               mem_q [DEPTH];
  logic [PW-1:0]      wr_q, rd_q;
  logic               first_q;
  logic [63:0]        base_q;
  logic               ovf_q, efill_q;
  logic [NRET-1:0]    oval_q;
  logic [NRET*64-1:0] oord_q;
  rec_t               out_q;

  grp_t               in_g, in_f, head, emit_g;
  rec_t               emit_r;
  logic [PW-1:0]      cnt;
  logic [AW-1:0]      toff;
  logic [NRET-1:0]    hi;
  logic [63:0]        pcnt;
  logic [NRET*64-1:0] ord_d;
  logic               grp_any, acc, late_bad, found;
  logic               fill_st, fill_in, fill_err;
  logic               pop_st, byp, emit, push, drop;

  assign cnt  = wr_q - rd_q;
  assign full = (cnt == PW'(DEPTH));

  always_comb begin
    in_g             = '0;
    in_g.valid       = n_valid;
    in_g.late        = n_late & n_valid;
    in_g.r.insn      = n_insn;
    in_g.r.trap      = n_trap;
    in_g.r.intr      = n_intr;
    in_g.r.rs1_addr  = n_rs1_addr;
    in_g.r.rs2_addr  = n_rs2_addr;
    in_g.r.rd_addr   = n_rd_addr;
    in_g.r.rs1_rdata = n_rs1_rdata;
    in_g.r.rs2_rdata = n_rs2_rdata;
    in_g.r.rd_wdata  = n_rd_wdata;
    in_g.r.pc_rdata  = n_pc_rdata;
    in_g.r.pc_wdata  = n_pc_wdata;
    in_g.r.mem_addr  = n_mem_addr;
    in_g.r.mem_wdata = n_mem_wdata;
    in_g.r.mem_rdata = n_mem_rdata;
    in_g.r.mem_rmask = n_mem_rmask;
    in_g.r.mem_wmask = n_mem_wmask;
  end

  always_comb begin
    grp_any = |n_valid;
    acc     = grp_any && !((SKIP_FIRST != 0) && !first_q);
    hi      = '0;
    for (int l = 0; l < NRET; l++) begin
      if (n_valid[l]) begin
        hi    = '0;
        hi[l] = 1'b1;
      end
    end
    // only the highest valid lane may carry late data
    late_bad = acc && (n_late != '0) && (n_late != hi);

    found = 1'b0;
    toff  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (!found && (PW'(k) < cnt) &&
          (mem_q[rd_q[AW-1:0] + AW'(k)].late != '0)) begin
        found = 1'b1;
        toff  = AW'(k);
      end
    end
    // with nothing stored waiting, an arriving late group takes the fill
    fill_st  = n_fill_valid && found;
    fill_in  = n_fill_valid && !found && acc && (in_g.late != '0);
    fill_err = n_fill_valid && !fill_st && !fill_in;

    in_f = fill_in ? fill_grp(in_g, n_fill_rd_wdata, n_fill_mem_rdata)
                   : in_g;
    head = mem_q[rd_q[AW-1:0]];
    if (fill_st && (toff == '0))
      head = fill_grp(head, n_fill_rd_wdata, n_fill_mem_rdata);

    pop_st = (cnt != '0) && (head.late == '0);
    byp    = (cnt == '0) && acc && (in_f.late == '0);
    emit   = pop_st || byp;
    emit_g = pop_st ? head : in_f;
    push   = acc && !byp && (!full || pop_st);
    drop   = acc && !byp && full && !pop_st;

    emit_r = emit_g.r;
    pcnt   = '0;
    ord_d  = '0;
    for (int l = 0; l < NRET; l++) begin
      if (emit_g.r.rd_addr[l*5 +: 5] == 5'd0)
        emit_r.rd_wdata[l*XLEN +: XLEN] = '0;
      pcnt = pcnt + 64'(emit_g.valid[l]);
      ord_d[l*64 +: 64] = base_q + 64'(l);
    end
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      first_q <= 1'b0;
      base_q  <= '0;
      ovf_q   <= 1'b0;
      efill_q <= 1'b0;
      oval_q  <= '0;
      oord_q  <= '0;
      out_q   <= '0;
    end else begin
      first_q <= first_q | grp_any;
      if (push)
        wr_q <= wr_q + 1'b1;
      if (pop_st)
        rd_q <= rd_q + 1'b1;
      ovf_q   <= ovf_q | drop;
      efill_q <= efill_q | fill_err | late_bad;
      oval_q  <= emit ? emit_g.valid : '0;
      if (emit) begin
        out_q  <= emit_r;
        oord_q <= ord_d;
        base_q <= base_q + pcnt;
      end
    end
  end

  // push after fill so a full-buffer push into the popped head slot wins
  always_ff @(posedge g_clk) begin
    if (fill_st)
      mem_q[rd_q[AW-1:0] + toff] <=
        fill_grp(mem_q[rd_q[AW-1:0] + toff],
                 n_fill_rd_wdata, n_fill_mem_rdata);
    if (push)
      mem_q[wr_q[AW-1:0]] <= in_f;
  end

  assign err_ovf        = ovf_q;
  assign err_fill       = efill_q;
  assign rvfi_valid     = oval_q;
  assign rvfi_order     = oord_q;
  assign rvfi_insn      = out_q.insn;
  assign rvfi_trap      = out_q.trap;
  assign rvfi_intr      = out_q.intr;
  assign rvfi_rs1_addr  = out_q.rs1_addr;
  assign rvfi_rs2_addr  = out_q.rs2_addr;
  assign rvfi_rs1_rdata = out_q.rs1_rdata;
  assign rvfi_rs2_rdata = out_q.rs2_rdata;
  assign rvfi_rd_addr   = out_q.rd_addr;
  assign rvfi_rd_wdata  = out_q.rd_wdata;
  assign rvfi_pc_rdata  = out_q.pc_rdata;
  assign rvfi_pc_wdata  = out_q.pc_wdata;
  assign rvfi_mem_addr  = out_q.mem_addr;
  assign rvfi_mem_rmask = out_q.mem_rmask;
  assign rvfi_mem_wmask = out_q.mem_wmask;
  assign rvfi_mem_rdata = out_q.mem_rdata;
  assign rvfi_mem_wdata = out_q.mem_wdata;

endmodule

// File: tb/tb_core_rvfi_rob.sv
// Bench for core_rvfi_rob: queue-based reference model and a
// scoreboard monitor checking rvfi_* contents, timing and flags.
module tb_core_rvfi_rob;
  localparam int NR = 2;
  localparam int DP = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]       valid, late, trap;
    logic [1:0][31:0] insn, pc, npc, rdw, mrd;
    logic [1:0][4:0]  rd;
  } g_t;

  typedef struct packed {
    g_t          g;
    logic [63:0] base;
    logic [31:0] cyc;
  } e_t;

  g_t          cur;
  logic        fv;
  logic [31:0] frd, fmr;
  logic [1:0]  intr;
  logic [9:0]  rs1a, rs2a;
  logic [63:0] rs1d, rs2d, maddr, mwd;
  logic [7:0]  rmsk, wmsk;

  logic [1:0]   rvfi_valid, rvfi_trap, rvfi_intr;
  logic [127:0] rvfi_order;
  logic [63:0]  rvfi_insn, rvfi_rs1_rdata, rvfi_rs2_rdata;
  logic [63:0]  rvfi_rd_wdata, rvfi_pc_rdata, rvfi_pc_wdata;
  logic [63:0]  rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata;
  logic [9:0]   rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr;
  logic [7:0]   rvfi_mem_rmask, rvfi_mem_wmask;
  logic         full, err_ovf, err_fill;

  core_rvfi_rob #(.NRET(NR), .XLEN(32), .ILEN(32), .DEPTH(DP),
                  .SKIP_FIRST(1)) dut (
    .g_clk(clk), .g_reset(rst),
    .n_valid(cur.valid), .n_insn(cur.insn), .n_intr(intr),
    .n_trap(cur.trap), .n_rs1_addr(rs1a), .n_rs2_addr(rs2a),
    .n_rs1_rdata(rs1d), .n_rs2_rdata(rs2d), .n_rd_addr(cur.rd),
    .n_rd_wdata(cur.rdw), .n_late(cur.late), .n_pc_rdata(cur.pc),
    .n_pc_wdata(cur.npc), .n_mem_addr(maddr), .n_mem_wdata(mwd),
    .n_mem_rmask(rmsk), .n_mem_wmask(wmsk), .n_mem_rdata(cur.mrd),
    .n_fill_valid(fv), .n_fill_rd_wdata(frd), .n_fill_mem_rdata(fmr),
    .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order),
    .rvfi_insn(rvfi_insn), .rvfi_trap(rvfi_trap),
    .rvfi_intr(rvfi_intr), .rvfi_rs1_addr(rvfi_rs1_addr),
    .rvfi_rs2_addr(rvfi_rs2_addr), .rvfi_rs1_rdata(rvfi_rs1_rdata),
    .rvfi_rs2_rdata(rvfi_rs2_rdata), .rvfi_rd_addr(rvfi_rd_addr),
    .rvfi_rd_wdata(rvfi_rd_wdata), .rvfi_pc_rdata(rvfi_pc_rdata),
    .rvfi_pc_wdata(rvfi_pc_wdata), .rvfi_mem_addr(rvfi_mem_addr),
    .rvfi_mem_rmask(rvfi_mem_rmask), .rvfi_mem_wmask(rvfi_mem_wmask),
    .rvfi_mem_rdata(rvfi_mem_rdata), .rvfi_mem_wdata(rvfi_mem_wdata),
    .full(full), .err_ovf(err_ovf), .err_fill(err_fill)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  g_t          held[$];
  e_t          exq[$];
  logic [63:0] m_base;
  bit          m_first, m_eovf, m_efill;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  function automatic g_t fillg(g_t g);
    g_t f = g;
    for (int l = 0; l < 2; l++)
      if (g.late[l]) begin
        f.rdw[l] = frd;
        f.mrd[l] = fmr;
      end
    f.late = 2'b00;
    return f;
  endfunction

  function automatic bit any_pend();
    foreach (held[i]) if (held[i].late != 0) return 1'b1;
    return 1'b0;
  endfunction

  // One cycle of the retirement rules applied to the inputs just sampled
  task automatic model_step();
    g_t g, eg;
    bit acc, popped, emitted;
    int idx, pre;
    e_t e;
    g = cur;
    g.late = cur.late & cur.valid;
    acc = (cur.valid != 0);
    eg = '0;
    if (acc && !m_first) begin
      m_first = 1'b1;
      acc = 1'b0;
    end
    if (acc && cur.late != 0 &&
        cur.late != (cur.valid[1] ? 2'b10 : 2'b01))
      m_efill = 1'b1;
    if (fv) begin
      idx = -1;
      foreach (held[i]) if (idx < 0 && held[i].late != 0) idx = i;
      if (idx >= 0) held[idx] = fillg(held[idx]);
      else if (acc && g.late != 0) g = fillg(g);
      else m_efill = 1'b1;
    end
    pre = held.size();
    popped = 0;
    emitted = 0;
    if (pre > 0 && held[0].late == 0) begin
      eg = held.pop_front();
      popped = 1;
      emitted = 1;
    end else if (pre == 0 && acc && g.late == 0) begin
      eg = g;
      acc = 0;
      emitted = 1;
    end
    if (acc) begin
      if (pre == DP && !popped) m_eovf = 1'b1;
      else held.push_back(g);
    end
    if (emitted) begin
      for (int l = 0; l < 2; l++) if (eg.rd[l] == 0) eg.rdw[l] = 0;
      e.g = eg;
      e.base = m_base;
      e.cyc = cyc;
      exq.push_back(e);
      m_base += 64'($countones(eg.valid));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    cur = '0;
    fv = 0;
    frd = '0;
    fmr = '0;
    intr = 2'($urandom);
    rs1a = 10'($urandom);
    rs2a = 10'($urandom);
    rs1d = {$urandom, $urandom};
    rs2d = {$urandom, $urandom};
    maddr = {$urandom, $urandom};
    mwd = {$urandom, $urandom};
    rmsk = 8'($urandom);
    wmsk = 8'($urandom);
  endtask

  function automatic g_t mkg(logic [1:0] v, logic [31:0] pc,
                             logic [4:0] rd0, logic [31:0] rdw0,
                             logic [1:0] late);
    g_t g;
    g.valid = v;
    g.late = late;
    g.trap = 2'($urandom) & v;
    g.insn[0] = $urandom;
    g.insn[1] = $urandom;
    g.pc[0] = pc;
    g.pc[1] = pc + 4;
    g.npc[0] = pc + 4;
    g.npc[1] = pc + 8;
    g.rd[0] = rd0;
    g.rd[1] = 5'($urandom);
    g.rdw[0] = rdw0;
    g.rdw[1] = $urandom;
    g.mrd[0] = $urandom;
    g.mrd[1] = $urandom;
    return g;
  endfunction

  task automatic reset_checks();
    chk("rst_valid", rvfi_valid, 0);
    chk("rst_order", rvfi_order[63:0], 0);
    chk("rst_pc", rvfi_pc_rdata, 0);
    chk("rst_full", full, 0);
    chk("rst_ovf", err_ovf, 0);
    chk("rst_efill", err_fill, 0);
  endtask

  task automatic areset();
    #6;
    rst = 1'b1;
    #1;
    reset_checks();
    rst = 1'b0;
    held.delete();
    exq.delete();
    m_base = 0;
    m_first = 0;
    m_eovf = 0;
    m_efill = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while ((held.size() != 0 || exq.size() != 0) && n < 60) begin
      if (any_pend()) begin
        fv = 1;
        frd = $urandom;
        fmr = $urandom;
      end
      tick();
      n++;
    end
    idle(1);
    chk(nm, exq.size() + held.size(), 0);
  endtask

  always @(negedge clk) begin : mon
    e_t e;
    if (!rst) begin
      chk("full", full, held.size() == DP);
      chk("err_ovf", err_ovf, m_eovf);
      chk("err_fill", err_fill, m_efill);
      if (rvfi_valid != 0) begin
        if (exq.size() == 0) begin
          chk("unexpected_emit", rvfi_valid, 0);
        end else begin
          e = exq.pop_front();
          chk("valid", rvfi_valid, e.g.valid);
          chk("latency", cyc, e.cyc);
          for (int l = 0; l < 2; l++) begin
            if (e.g.valid[l]) begin
              chk("order", rvfi_order[l*64 +: 64], e.base + 64'(l));
              chk("pc", rvfi_pc_rdata[l*32 +: 32], e.g.pc[l]);
              chk("npc", rvfi_pc_wdata[l*32 +: 32], e.g.npc[l]);
              chk("insn", rvfi_insn[l*32 +: 32], e.g.insn[l]);
              chk("trap", rvfi_trap[l], e.g.trap[l]);
              chk("rd", rvfi_rd_addr[l*5 +: 5], e.g.rd[l]);
              chk("rd_wdata", rvfi_rd_wdata[l*32 +: 32], e.g.rdw[l]);
              chk("mem_rdata", rvfi_mem_rdata[l*32 +: 32], e.g.mrd[l]);
            end
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    cur = '0;
    fv = 0;
    frd = '0;
    fmr = '0;
    intr = '0;
    rs1a = '0;
    rs2a = '0;
    rs1d = '0;
    rs2d = '0;
    maddr = '0;
    mwd = '0;
    rmsk = '0;
    wmsk = '0;
    m_base = 0;
    m_first = 0;
    m_eovf = 0;
    m_efill = 0;
    #1;
    reset_checks();
    @(posedge clk);
    #3 rst = 1'b0;

    // first group is a fill bubble; pc 0x4/0x8 get orders 0/1
    cur = mkg(2'b01, 32'h0, 5'd1, 32'h11, 2'b00); tick();
    cur = mkg(2'b01, 32'h4, 5'd2, 32'h22, 2'b00); tick();
    cur = mkg(2'b01, 32'h8, 5'd3, 32'h33, 2'b00); tick();
    idle(2);

    // late load blocks two younger groups until filled
    cur = mkg(2'b01, 32'h10, 5'd5, 32'h55, 2'b01); tick();
    cur = mkg(2'b01, 32'h14, 5'd6, 32'h66, 2'b00); tick();
    cur = mkg(2'b01, 32'h18, 5'd7, 32'h77, 2'b00); tick();
    fv = 1; frd = 32'hDEAD; fmr = 32'hBEEF; tick();
    idle(3);

    // x0 destination, immediate and filled
    cur = mkg(2'b01, 32'h20, 5'd0, 32'h1234, 2'b00); tick();
    cur = mkg(2'b01, 32'h24, 5'd0, 32'h5678, 2'b01); tick();
    fv = 1; frd = 32'hCAFE; fmr = 32'h1; tick();
    idle(2);

    // overflow: pending head plus four groups, last one dropped
    cur = mkg(2'b01, 32'h30, 5'd9, 32'h0, 2'b01); tick();
    for (int i = 0; i < 4; i++) begin
      cur = mkg(2'b01, 32'h34 + 32'(4*i), 5'd10, 32'(i), 2'b00);
      tick();
    end
    chk("ovf_full", full, 1);
    chk("ovf_err", err_ovf, 1);
    fv = 1; frd = 32'h4242; fmr = 32'h4343; tick();
    drain("drain_ovf");
    areset();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      int r = $urandom_range(0, 7);
      logic [1:0] v = (r < 2) ? 2'b00 : ((r < 6) ? 2'b01 : 2'b11);
      logic [1:0] lt = 2'b00;
      if (v != 0 && $urandom_range(0, 3) == 0)
        lt = v[1] ? 2'b10 : 2'b01;
      cur = mkg(v, $urandom, ($urandom_range(0, 3) == 0) ? 5'd0
                : 5'($urandom), $urandom, lt);
      if (any_pend() && $urandom_range(0, 2) == 0) begin
        fv = 1;
        frd = $urandom;
        fmr = $urandom;
      end
      tick();
    end
    drain("drain_rand");
    areset();

    // two-lane groups after a fresh reset: orders {0,1} then {2}
    cur = mkg(2'b01, 32'h100, 5'd1, 32'h1, 2'b00); tick();
    cur = mkg(2'b11, 32'h200, 5'd2, 32'h2, 2'b00); tick();
    cur = mkg(2'b01, 32'h300, 5'd3, 32'h3, 2'b00); tick();
    idle(2);
    fv = 1; frd = 32'h9; fmr = 32'h9; tick();
    chk("fill_idle_err", err_fill, 1);
    drain("drain_nret2");
    areset();

    // reset while a late group waits; the later fill has no target
    cur = mkg(2'b01, 32'h400, 5'd1, 32'h1, 2'b00); tick();
    cur = mkg(2'b01, 32'h404, 5'd4, 32'h44, 2'b00); tick();
    cur = mkg(2'b01, 32'h408, 5'd8, 32'h88, 2'b01); tick();
    cur = mkg(2'b01, 32'h40c, 5'd9, 32'h99, 2'b00); tick();
    chk("pre_rst_pc", rvfi_pc_rdata[31:0], 32'h404);
    areset();
    idle(1);
    fv = 1; frd = 32'h7; fmr = 32'h7; tick();
    chk("post_rst_fill_err", err_fill, 1);
    idle(2);
    chk("final_drain", exq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
